// File: rtl/bldc_commutator_if.sv
// Drive-side bundle of the six-step commutator: motion/duty controls in,
// sector status and per-phase leg drive out. The controller is the master,
// the commutator is the slave.
interface bldc_commutator_if #(
  parameter int unsigned SUB_PHASE_WIDTH = 8,
  parameter int unsigned PWM_WIDTH       = 8
);

  // Controls
  logic                       enable;
  logic                       dir;
  logic [SUB_PHASE_WIDTH-1:0] phase_step;
  logic [PWM_WIDTH-1:0]       duty;

  // Status
  logic [2:0]                 sector;
  logic                       sector_change;

  // Per-phase drive: en = leg driven, hl = 1 high side / 0 low side
  logic                       bldc_u_en;
  logic                       bldc_v_en;
  logic                       bldc_w_en;
  logic                       bldc_u_hl;
  logic                       bldc_v_hl;
  logic                       bldc_w_hl;

  modport master (
    output enable, dir, phase_step, duty,
    input  sector, sector_change,
    input  bldc_u_en, bldc_v_en, bldc_w_en,
    input  bldc_u_hl, bldc_v_hl, bldc_w_hl
  );

  modport slave (
    input  enable, dir, phase_step, duty,
    output sector, sector_change,
    output bldc_u_en, bldc_v_en, bldc_w_en,
    output bldc_u_hl, bldc_v_hl, bldc_w_hl
  );

endinterface

// File: rtl/bldc_commutator.sv
// Six-step BLDC commutation stage.
// A sub-phase accumulator advances the electrical sector on each carry; the
// sector selects one high-side leg (chopped by a free-running PWM compare)
// and one low-side leg. Every sector change and every enable rise blanks all
// leg enables for DEAD_TIME cycles plus the cycle of the event itself, so a
// leg's side select never changes while that leg is being driven.
// The interface instance must be built with the same SUB_PHASE_WIDTH and
// PWM_WIDTH as this module.
module bldc_commutator #(
  parameter int unsigned SUB_PHASE_WIDTH = 8,
  parameter int unsigned PWM_WIDTH       = 8,
  parameter int unsigned DEAD_TIME       = 16,
  parameter int unsigned DEAD_WIDTH      = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  bldc_commutator_if.slave   bus
);

  // Legs are carried as 3-bit vectors ordered {w, v, u}.
  typedef logic [2:0] leg_vec_t;

  typedef struct packed {
    leg_vec_t hi;   // leg driven on the high side (PWM chopped)
    leg_vec_t lo;   // leg driven on the low side (always on)
  } leg_sel_t;

  localparam logic [2:0]            SECTOR_LAST = 3'd5;
  localparam logic [DEAD_WIDTH-1:0] DEAD_LOAD   = DEAD_WIDTH'(DEAD_TIME);

  // Commutation table: sector -> high leg / low leg.
  function automatic leg_sel_t commutate(input logic [2:0] s);
    leg_sel_t sel;
    case (s)
      3'd0:    sel = '{hi: 3'b001, lo: 3'b010};  // U H, V L
      3'd1:    sel = '{hi: 3'b001, lo: 3'b100};  // U H, W L
      3'd2:    sel = '{hi: 3'b010, lo: 3'b100};  // V H, W L
      3'd3:    sel = '{hi: 3'b010, lo: 3'b001};  // V H, U L
      3'd4:    sel = '{hi: 3'b100, lo: 3'b001};  // W H, U L
      3'd5:    sel = '{hi: 3'b100, lo: 3'b010};  // W H, V L
      default: sel = '{hi: 3'b000, lo: 3'b000};  // unreachable: all legs off
    endcase
    return sel;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [SUB_PHASE_WIDTH-1:0] acc_q,           acc_d;
  logic [2:0]                 sector_q,        sector_d;
  logic                       sector_change_q, sector_change_d;
  logic [PWM_WIDTH-1:0]       pwm_cnt_q,       pwm_cnt_d;
  logic [DEAD_WIDTH-1:0]      dead_cnt_q,      dead_cnt_d;
  logic                       enable_q,        enable_d;   // enable seen last cycle
  leg_vec_t                   en_q,            en_d;
  leg_vec_t                   hl_q,            hl_d;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic [SUB_PHASE_WIDTH:0] acc_sum;
  logic                     carry;
  logic                     enable_rise;
  logic                     dead_load;
  logic                     pwm_on;
  leg_sel_t                 sel;

  // Accumulator sum, event detection and PWM compare.
  always_comb begin
    acc_sum     = {1'b0, acc_q} + {1'b0, bus.phase_step};
    carry       = bus.enable & acc_sum[SUB_PHASE_WIDTH];
    enable_rise = bus.enable & ~enable_q;
    dead_load   = carry | enable_rise;
    pwm_on      = (pwm_cnt_q < bus.duty);
    sel         = commutate(sector_q);
  end

  // Accumulator and sector advance; sector frozen while disabled.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path through
    // this block can leave a value unassigned and infer a latch.
    acc_d           = acc_q;
    sector_d        = sector_q;
    sector_change_d = 1'b0;
    if (bus.enable) begin
      acc_d = acc_sum[SUB_PHASE_WIDTH-1:0];
      if (carry) begin
        sector_change_d = 1'b1;
        if (bus.dir) begin
          sector_d = (sector_q == 3'd0 || sector_q > SECTOR_LAST) ? SECTOR_LAST
                                                                 : sector_q - 3'd1;
        end else begin
          sector_d = (sector_q >= SECTOR_LAST) ? 3'd0 : sector_q + 3'd1;
        end
      end
    end
  end

  // Free-running PWM counter, independent of enable.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_WIDTH'(1);
  end

  // Dead-time counter: load on sector change or enable rise, count down to 0,
  // cleared while disabled so the next enable rise starts a fresh window.
  always_comb begin
    enable_d   = bus.enable;
    dead_cnt_d = dead_cnt_q;
    if (!bus.enable) begin
      dead_cnt_d = '0;
    end else if (dead_load) begin
      dead_cnt_d = DEAD_LOAD;
    end else if (dead_cnt_q != '0) begin
      dead_cnt_d = dead_cnt_q - DEAD_WIDTH'(1);
    end
  end

  // Leg drive from the current sector/dead-time/PWM state. The event cycle is
  // blanked as well, so the hl update one cycle later always meets en = 0.
  always_comb begin
    en_d = '0;
    hl_d = hl_q;
    if (bus.enable) begin
      hl_d = sel.hi;
      if (dead_cnt_q == '0 && !dead_load) begin
        en_d = (sel.hi & {3{pwm_on}}) | sel.lo;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // All state flops with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values
    // of the others; blocking here would create order-dependent races.
    if (!reset_n) begin
      acc_q           <= '0;
      sector_q        <= '0;
      sector_change_q <= 1'b0;
      pwm_cnt_q       <= '0;
      dead_cnt_q      <= '0;
      enable_q        <= 1'b0;
      en_q            <= '0;
      hl_q            <= '0;
    end else begin
      acc_q           <= acc_d;
      sector_q        <= sector_d;
      sector_change_q <= sector_change_d;
      pwm_cnt_q       <= pwm_cnt_d;
      dead_cnt_q      <= dead_cnt_d;
      enable_q        <= enable_d;
      en_q            <= en_d;
      hl_q            <= hl_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.sector        = sector_q;
  assign bus.sector_change = sector_change_q;
  assign bus.bldc_u_en     = en_q[0];
  assign bus.bldc_v_en     = en_q[1];
  assign bus.bldc_w_en     = en_q[2];
  assign bus.bldc_u_hl     = hl_q[0];
  assign bus.bldc_v_hl     = hl_q[1];
  assign bus.bldc_w_hl     = hl_q[2];

endmodule

// File: tb/tb_bldc_commutator.sv
// Bench for bldc_commutator: directed scenarios followed by a randomized run,
// every cycle compared against a cycle-level behavioural model of the drive.
module tb_bldc_commutator;

  localparam int DEAD_TIME = 16;

  logic clk = 1'b0;
  logic reset_n;

  bldc_commutator_if #(.SUB_PHASE_WIDTH(8), .PWM_WIDTH(8)) bus ();

  bldc_commutator #(
    .SUB_PHASE_WIDTH(8),
    .PWM_WIDTH      (8),
    .DEAD_TIME      (DEAD_TIME),
    .DEAD_WIDTH     (8)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------------------------------------------------------------------
  // Reference model: legs indexed u=0, v=1, w=2. Dead time is tracked as the
  // number of clock edges elapsed since the last blanking event.
  // ---------------------------------------------------------------------------
  int       hi_leg [6] = '{0, 0, 1, 1, 2, 2};
  int       lo_leg [6] = '{1, 2, 2, 0, 0, 1};
  int       m_acc    = 0;
  int       m_sector = 0;
  int       m_pwm    = 0;
  int       m_since  = 0;
  bit       m_prev_en = 0;
  bit       m_chg    = 0;
  bit [2:0] m_en     = '0;
  bit [2:0] m_hl     = '0;
  bit       m_rst_edge = 0;

  bit [2:0] prev_en = '0;
  bit [2:0] prev_hl = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] obs_en();
    return {bus.bldc_w_en, bus.bldc_v_en, bus.bldc_u_en};
  endfunction

  function automatic logic [2:0] obs_hl();
    return {bus.bldc_w_hl, bus.bldc_v_hl, bus.bldc_u_hl};
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    int sum;
    bit carry;
    bit event_hit;
    bit pwm_on;
    m_rst_edge = !reset_n;
    if (!reset_n) begin
      m_acc = 0; m_sector = 0; m_pwm = 0; m_since = 0;
      m_prev_en = 0; m_chg = 0; m_en = '0; m_hl = '0;
      return;
    end
    if (bus.enable) begin
      sum       = m_acc + int'(bus.phase_step);
      carry     = (sum >= 256);
      event_hit = carry || !m_prev_en;
      pwm_on    = (m_pwm < int'(bus.duty));
      m_hl = '0;
      m_hl[hi_leg[m_sector]] = 1'b1;
      m_en = '0;
      if (!event_hit && m_since >= DEAD_TIME) begin
        m_en[hi_leg[m_sector]] = pwm_on;
        m_en[lo_leg[m_sector]] = 1'b1;
      end
      m_since = event_hit ? 0 : ((m_since < 100000) ? m_since + 1 : m_since);
      m_acc   = sum % 256;
      if (carry) m_sector = bus.dir ? (m_sector + 5) % 6 : (m_sector + 1) % 6;
      m_chg = carry;
    end else begin
      m_en  = '0;
      m_chg = 1'b0;
    end
    m_prev_en = bus.enable;
    m_pwm     = (m_pwm + 1) % 256;
  endtask

  // One clock: model, edge, then compare outputs 1 ns after the edge.
  task automatic tick();
    logic [2:0] en;
    logic [2:0] hl;
    model_step();
    @(posedge clk);
    #1;
    en = obs_en();
    hl = obs_hl();
    check("sector",        {29'd0, bus.sector}, m_sector);
    check("sector_change", {31'd0, bus.sector_change}, {31'd0, m_chg});
    check("leg_en",        {29'd0, en}, {29'd0, m_en});
    check("leg_hl",        {29'd0, hl}, {29'd0, m_hl});
    check("en_at_most_two", {31'd0, ($countones(en) <= 2)}, 1);
    if (!m_rst_edge) check("hl_stable_while_driven", {29'd0, prev_en & (hl ^ prev_hl)}, 0);
    prev_en = en;
    prev_hl = hl;
  endtask

  task automatic goto_sector(input int target, input int budget, input string tag);
    int n = 0;
    while (m_sector != target && n < budget) begin
      tick();
      n++;
    end
    check(tag, {29'd0, bus.sector}, target);
  endtask

  task automatic wait_change(input int target, input int budget, input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!m_chg && n < budget);
    check(tag, {29'd0, bus.sector}, target);
  endtask

  initial begin
    int n_chg;
    int cnt_u, cnt_v, cnt_w;

    // Reset held with the motor requested on.
    reset_n        = 1'b0;
    bus.enable     = 1'b1;
    bus.dir        = 1'b0;
    bus.phase_step = 8'h40;
    bus.duty       = 8'd255;
    repeat (10) tick();
    check("rst_sector", {29'd0, bus.sector}, 0);
    check("rst_chg",    {31'd0, bus.sector_change}, 0);
    check("rst_en",     {29'd0, obs_en()}, 0);
    check("rst_hl",     {29'd0, obs_hl()}, 0);

    // Forward, one change per 4 clocks: dead time keeps reloading.
    reset_n = 1'b1;
    n_chg = 0;
    repeat (40) begin
      tick();
      if (bus.sector_change) n_chg++;
      check("fwd_fast_en_blank", {29'd0, obs_en()}, 0);
    end
    check("fwd_fast_changes", n_chg, 10);

    // Forward, one change per 256 clocks: full table visited.
    bus.phase_step = 8'd1;
    repeat (6 * 256 + 20) tick();

    // Reverse wrap from sector 0.
    bus.phase_step = 8'h40;
    goto_sector(0, 400, "goto_s0_rev");
    bus.dir = 1'b1;
    wait_change(5, 10, "rev_wrap_to_5");
    check("rev_wrap_pulse", {31'd0, bus.sector_change}, 1);
    tick();
    check("rev_s5_hl", {29'd0, obs_hl()}, 3'b100);
    wait_change(4, 10, "rev_then_4");

    // PWM duty in sector 0.
    bus.dir = 1'b0;
    goto_sector(0, 40, "goto_s0_pwm");
    bus.phase_step = 8'd0;
    bus.duty       = 8'd64;
    repeat (20) tick();
    cnt_u = 0; cnt_v = 0; cnt_w = 0;
    repeat (256) begin
      tick();
      cnt_u += int'(bus.bldc_u_en);
      cnt_v += int'(bus.bldc_v_en);
      cnt_w += int'(bus.bldc_w_en);
    end
    check("duty64_u_on", cnt_u, 64);
    check("duty64_v_on", cnt_v, 256);
    check("duty64_w_on", cnt_w, 0);
    bus.duty = 8'd0;
    cnt_u = 0;
    repeat (256) begin
      tick();
      cnt_u += int'(bus.bldc_u_en);
    end
    check("duty0_u_on", cnt_u, 0);

    // Dead-time reload: second carry 5 cycles after the first.
    bus.duty = 8'd255;
    if (m_acc == 0) begin
      bus.phase_step = 8'd128;
      tick();
    end
    bus.phase_step = 8'(256 - m_acc);
    tick();
    check("reload_first_chg", {31'd0, bus.sector_change}, 1);
    bus.phase_step = 8'd0;
    repeat (3) tick();
    bus.phase_step = 8'd128;
    tick();
    tick();
    check("reload_second_chg", {31'd0, bus.sector_change}, 1);
    check("reload_sector", {29'd0, bus.sector}, 2);
    bus.phase_step = 8'd0;
    repeat (DEAD_TIME) begin
      tick();
      check("reload_en_blank", {29'd0, obs_en()}, 0);
    end
    tick();
    check("reload_resume_w_low", {31'd0, bus.bldc_w_en}, 1);

    // Enable toggle mid-sector.
    bus.enable = 1'b0;
    tick();
    check("dis_en_off", {29'd0, obs_en()}, 0);
    bus.phase_step = 8'h40;
    repeat (4) tick();
    check("dis_sector_frozen", {29'd0, bus.sector}, 2);
    bus.phase_step = 8'd0;
    bus.enable = 1'b1;
    repeat (DEAD_TIME + 1) begin
      tick();
      check("reen_en_blank", {29'd0, obs_en()}, 0);
    end
    tick();
    check("reen_resume_w_low", {31'd0, bus.bldc_w_en}, 1);
    check("reen_same_sector", {29'd0, bus.sector}, 2);

    // Randomized run with a reset mid-operation.
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) reset_n = 1'b0;
      if (c == 1503) reset_n = 1'b1;
      if ($urandom_range(63) == 0)  bus.enable = ~bus.enable;
      if ($urandom_range(127) == 0) bus.dir    = ~bus.dir;
      if (c % 150 == 0) begin
        case ($urandom_range(3))
          0:       bus.phase_step = 8'($urandom_range(3));
          1:       bus.phase_step = 8'($urandom_range(32, 4));
          2:       bus.phase_step = 8'($urandom);
          default: bus.phase_step = 8'd0;
        endcase
      end
      if (c % 200 == 0) bus.duty = 8'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
